// File: rtl/sum_bist_pkg.sv
// Shared types and default sizing for the my_sum self-test sequencer.
package sum_bist_pkg;

  localparam int DEF_WIDTH  = 4;
  localparam int DEF_SETTLE = 2;
  localparam int VEC_W      = 2*DEF_WIDTH + 1;
  localparam int ERR_W      = 2*DEF_WIDTH + 2;
  localparam int CNT_W      = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } bist_state_e;

endpackage

// File: rtl/sum_ref_model.sv
// Combinational reference adder: {carry, sum} = a + b + ci, WIDTH+1 bits wide.
module sum_ref_model #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             ci_i,
  output logic [WIDTH:0]   sum_o
);

  assign sum_o = {1'b0, a_i} + {1'b0, b_i} + {{WIDTH{1'b0}}, ci_i};

endmodule

// File: rtl/sum_bist_driver.sv
// Exhaustive self-test sweep for a WIDTH-bit ripple adder (A, B, Ci -> sum, co).
// Define STOP_ON_FAIL_EN to end the sweep at the first mismatch with operands held.
module sum_bist_driver
  import sum_bist_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int SETTLE = DEF_SETTLE
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic [WIDTH-1:0]   Ain,
  output logic [WIDTH-1:0]   Bin,
  output logic               Ci,
  input  logic [WIDTH-1:0]   res_in,
  input  logic               co_in,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [2*WIDTH+1:0] err_count,
  output logic [WIDTH-1:0]   fail_a,
  output logic [WIDTH-1:0]   fail_b,
  output logic               fail_ci
);

  localparam int IW = 2*WIDTH + 1;
  localparam int EW = 2*WIDTH + 2;
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE - 1);
  localparam logic [IW-1:0]    IDX_LAST    = {IW{1'b1}};

  bist_state_e      state_q;
  logic [IW-1:0]    idx_q;
  logic [CNT_W-1:0] cnt_q;
  logic [EW-1:0]    err_q;
  logic [EW-1:0]    err_d;
  logic             seen_q;
  logic             busy_q;
  logic             done_q;
  logic             pass_q;
  logic [WIDTH-1:0] fail_a_q;
  logic [WIDTH-1:0] fail_b_q;
  logic             fail_ci_q;
  logic [WIDTH:0]   ref_sum;
  logic             mismatch;

  // Operands are a pure decode of the registered index: {Ci, Ain, Bin}.
  assign Bin = idx_q[WIDTH-1:0];
  assign Ain = idx_q[2*WIDTH-1:WIDTH];
  assign Ci  = idx_q[2*WIDTH];

  sum_ref_model #(.WIDTH(WIDTH)) u_ref (
    .a_i  (Ain),
    .b_i  (Bin),
    .ci_i (Ci),
    .sum_o(ref_sum)
  );

  assign mismatch = (ref_sum != {co_in, res_in});

  // Error count as it will stand after the current CHECK cycle.
  always_comb begin
    err_d = err_q;
    if (mismatch) begin
      err_d = err_q + EW'(1);
    end else begin
      err_d = err_q;
    end
  end

  // Sweep sequencer with registered status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      cnt_q     <= '0;
      err_q     <= '0;
      seen_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
      fail_a_q  <= '0;
      fail_b_q  <= '0;
      fail_ci_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            state_q   <= WAIT;
            idx_q     <= '0;
            cnt_q     <= '0;
            err_q     <= '0;
            seen_q    <= 1'b0;
            busy_q    <= 1'b1;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
            fail_a_q  <= '0;
            fail_b_q  <= '0;
            fail_ci_q <= 1'b0;
          end
        end
        WAIT: begin
          cnt_q <= cnt_q + CNT_W'(1);
          if (cnt_q == SETTLE_LAST) begin
            state_q <= CHECK;
          end
        end
        CHECK: begin
          err_q <= err_d;
          if (mismatch && !seen_q) begin
            seen_q    <= 1'b1;
            fail_a_q  <= Ain;
            fail_b_q  <= Bin;
            fail_ci_q <= Ci;
          end
`ifdef STOP_ON_FAIL_EN
          if (mismatch || (idx_q == IDX_LAST)) begin
`else
          if (idx_q == IDX_LAST) begin
`endif
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            pass_q  <= (err_d == '0);
          end else begin
            state_q <= WAIT;
            idx_q   <= idx_q + IW'(1);
            cnt_q   <= '0;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign err_count = err_q;
  assign fail_a    = fail_a_q;
  assign fail_b    = fail_b_q;
  assign fail_ci   = fail_ci_q;

endmodule

// File: tb/tb_sum_bist_driver.sv
// Scoreboard bench for sum_bist_driver against a behavioural adder with injectable faults.
module tb_sum_bist_driver;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] Ain, Bin, res_in, fail_a, fail_b;
  logic       Ci, co_in, busy, done, pass, fail_ci;
  logic [9:0] err_count;
  logic [4:0] adder_sum;
  int         fault_mode;   // 0 good, 1 sum bit0 stuck-0, 2 carry-out stuck-0

  int checks = 0;
  int failures = 0;
  int busy_cnt = 0;
  logic done_prev = 1'b0;

  typedef struct {
    string name;
    int    err;
    int    pass;
    int    fa, fb, fci;
    int    a, b, ci;
    int    busy_cyc;
  } exp_t;

  exp_t exp_q[$];

  sum_bist_driver dut (
    .clk(clk), .rst(rst), .start(start),
    .Ain(Ain), .Bin(Bin), .Ci(Ci),
    .res_in(res_in), .co_in(co_in),
    .busy(busy), .done(done), .pass(pass), .err_count(err_count),
    .fail_a(fail_a), .fail_b(fail_b), .fail_ci(fail_ci)
  );

  always #5 clk = ~clk;

  always_comb begin
    adder_sum = {1'b0, Ain} + {1'b0, Bin} + {4'b0000, Ci};
    res_in = adder_sum[3:0];
    co_in  = adder_sum[4];
    if (fault_mode == 1) res_in[0] = 1'b0;
    if (fault_mode == 2) co_in = 1'b0;
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Monitor: counts busy cycles and scores each completed sweep.
  always @(negedge clk) begin
    if (rst) begin
      busy_cnt = 0;
    end else begin
      if (busy) busy_cnt++;
      if (done && !done_prev) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk({e.name, "_err_count"}, int'(err_count), e.err);
          chk({e.name, "_pass"}, int'(pass), e.pass);
          chk({e.name, "_fail_a"}, int'(fail_a), e.fa);
          chk({e.name, "_fail_b"}, int'(fail_b), e.fb);
          chk({e.name, "_fail_ci"}, int'(fail_ci), e.fci);
          chk({e.name, "_Ain"}, int'(Ain), e.a);
          chk({e.name, "_Bin"}, int'(Bin), e.b);
          chk({e.name, "_Ci"}, int'(Ci), e.ci);
          chk({e.name, "_busy_cycles"}, busy_cnt, e.busy_cyc);
          chk({e.name, "_busy_low"}, int'(busy), 0);
        end
        busy_cnt = 0;
      end
    end
    done_prev = done;
  end

  function automatic exp_t mk(input string name, input int err, input int ps,
                              input int fa, input int fb, input int fci,
                              input int a, input int b, input int ci, input int cyc);
    exp_t e;
    e.name = name; e.err = err; e.pass = ps;
    e.fa = fa; e.fb = fb; e.fci = fci;
    e.a = a; e.b = b; e.ci = ci; e.busy_cyc = cyc;
    return e;
  endfunction

  task automatic run(input exp_t e, input bit extra, input bit chk_clear);
    int n;
    exp_q.push_back(e);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    n = 1;
    if (chk_clear) begin
      chk({e.name, "_restart_err_clear"}, int'(err_count), 0);
      chk({e.name, "_restart_done_low"}, int'(done), 0);
      chk({e.name, "_restart_busy"}, int'(busy), 1);
    end
    while (!done && n < 3000) begin
      @(negedge clk);
      n++;
      start = extra && (n == 10 || n == 500);
    end
    start = 1'b0;
    if (!done) chk({e.name, "_timeout"}, 1, 0);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    exp_t e_good, e_b0, e_co;
    rst = 1'b1; start = 1'b0; fault_mode = 0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done), 0);
    chk("reset_pass", int'(pass), 0);
    chk("reset_err", int'(err_count), 0);
    chk("reset_ops", int'({Ci, Ain, Bin}), 0);
    chk("reset_fail", int'({fail_ci, fail_a, fail_b}), 0);

    e_good = mk("good", 0, 1, 0, 0, 0, 15, 15, 1, 1536);
`ifdef STOP_ON_FAIL_EN
    e_b0 = mk("bit0", 1, 0, 0, 1, 0, 0, 1, 0, 6);
    e_co = mk("carry", 1, 0, 1, 15, 0, 1, 15, 0, 96);
`else
    e_b0 = mk("bit0", 256, 0, 0, 1, 0, 15, 15, 1, 1536);
    e_co = mk("carry", 256, 0, 1, 15, 0, 15, 15, 1, 1536);
`endif

    fault_mode = 0; run(e_good, 1'b0, 1'b0);
    fault_mode = 1; run(e_b0, 1'b0, 1'b0);
    fault_mode = 0; e_good.name = "restart"; run(e_good, 1'b0, 1'b1);
    fault_mode = 2; run(e_co, 1'b0, 1'b0);

    // Abort a good sweep mid-way with reset.
    fault_mode = 0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (699) @(negedge clk);
    chk("pre_abort_busy", int'(busy), 1);
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(done), 0);
    chk("abort_ops", int'({Ci, Ain, Bin}), 0);
    chk("abort_err", int'(err_count), 0);
    chk("abort_fail", int'({fail_ci, fail_a, fail_b}), 0);
    repeat (5) @(negedge clk);
    chk("abort_idle", int'(busy), 0);
    e_good.name = "post_abort"; run(e_good, 1'b0, 1'b0);

    e_good.name = "ignored_start"; run(e_good, 1'b1, 1'b0);

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
